// File: rtl/mat_mul_mac.sv
// mat_mul_mac: C = A*B (MxK by KxN) with LANES parallel MACs over K, start/done handshake.
// Optional MAT_MUL_MAC_SAT_EN: saturating write-back plus a sat_flag output.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on accept
// S_CALC | one k-pass per cycle, k fastest, then j, then i
// S_DONE | last element written; next edge pulses done and returns to idle
module mat_mul_mac #(
  parameter int width = 32,
  parameter int M     = 3,
  parameter int K     = 3,
  parameter int N     = 3,
  parameter int LANES = 1,
  parameter int OUT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic [M*K*width-1:0]   a,
  input  logic [K*N*width-1:0]   b,
  output logic [M*N*OUT_W-1:0]   c,
  output logic                   busy,
  output logic                   done
`ifdef MAT_MUL_MAC_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int P     = (K + LANES - 1) / LANES;
  localparam int ACC_W = 2*width + $clog2(K) + 1;
  localparam int KPW   = (P > 1) ? $clog2(P) : 1;
  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int JW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                   r_state, w_state_nx;
  logic [M*K*width-1:0]     r_a;
  logic [K*N*width-1:0]     r_b;
  logic                     r_sm;
  logic [KPW-1:0]           r_kp;
  logic [IW-1:0]            r_i;
  logic [JW-1:0]            r_j;
  logic signed [ACC_W-1:0]  r_acc;
  logic [M*N*OUT_W-1:0]     r_c;
  logic                     r_busy, r_done;

  logic                     w_accept, w_last_pass, w_last_i, w_last_j;
  logic signed [width:0]    w_ea, w_eb;
  logic signed [2*width+1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic [OUT_W-1:0]         w_wb;

  assign w_last_pass = (r_kp == KPW'(P-1));
  assign w_last_i    = (r_i == IW'(M-1));
  assign w_last_j    = (r_j == JW'(N-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_accept   = 1'b1;
        w_state_nx = S_CALC;
      end
      S_CALC: if (w_last_pass && w_last_j && w_last_i) w_state_nx = S_DONE;
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operands are widened by one bit so a single signed multiply serves both modes.
  always_comb begin
    w_sum  = r_acc;
    w_ea   = '0;
    w_eb   = '0;
    w_prod = '0;
    for (int l = 0; l < LANES; l++) begin
      w_ea = '0;
      w_eb = '0;
      for (int kk = 0; kk < K; kk++) begin
        if (kk == int'(r_kp)*LANES + l) begin
          for (int ii = 0; ii < M; ii++)
            if (ii == int'(r_i))
              w_ea = {r_sm & r_a[(ii*K+kk)*width+width-1], r_a[(ii*K+kk)*width +: width]};
          for (int jj = 0; jj < N; jj++)
            if (jj == int'(r_j))
              w_eb = {r_sm & r_b[(kk*N+jj)*width+width-1], r_b[(kk*N+jj)*width +: width]};
        end
      end
      w_prod = w_ea * w_eb;
      w_sum  = w_sum + ACC_W'(w_prod);
    end
  end

`ifdef MAT_MUL_MAC_SAT_EN
  localparam int SW = ACC_W + OUT_W + 1;
  localparam logic signed [SW-1:0] S_MAX = signed'((SW'(1) << (OUT_W-1)) - SW'(1));
  localparam logic signed [SW-1:0] S_MIN = signed'(SW'(0) - (SW'(1) << (OUT_W-1)));
  localparam logic signed [SW-1:0] U_MAX = signed'((SW'(1) << OUT_W) - SW'(1));

  logic signed [SW-1:0] w_sx;
  logic                 w_clip;
  logic                 r_sat;

  always_comb begin
    w_sx   = SW'(w_sum);
    w_clip = 1'b0;
    w_wb   = OUT_W'(w_sum);
    if (r_sm) begin
      if (w_sx > S_MAX) begin
        w_wb   = OUT_W'(S_MAX);
        w_clip = 1'b1;
      end else if (w_sx < S_MIN) begin
        w_wb   = OUT_W'(S_MIN);
        w_clip = 1'b1;
      end
    end else if (w_sx > U_MAX) begin
      w_wb   = '1;
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         r_sat <= 1'b0;
    else if (w_accept)                                r_sat <= 1'b0;
    else if (r_state == S_CALC && w_last_pass && w_clip) r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`else
  assign w_wb = OUT_W'(w_sum);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sm   <= 1'b0;
      r_kp   <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_acc  <= '0;
      r_c    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) r_busy <= 1'b0;
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_sm   <= signed_mode;
        r_kp   <= '0;
        r_i    <= '0;
        r_j    <= '0;
        r_acc  <= '0;
        r_busy <= 1'b1;
      end else if (r_state == S_CALC) begin
        if (w_last_pass) begin
          for (int ii = 0; ii < M; ii++)
            for (int jj = 0; jj < N; jj++)
              if (ii == int'(r_i) && jj == int'(r_j))
                r_c[(ii*N+jj)*OUT_W +: OUT_W] <= w_wb;
          r_acc <= '0;
          r_kp  <= '0;
          if (w_last_j) begin
            r_j <= '0;
            r_i <= w_last_i ? '0 : r_i + IW'(1);
          end else begin
            r_j <= r_j + JW'(1);
          end
        end else begin
          r_acc <= w_sum;
          r_kp  <= r_kp + KPW'(1);
        end
      end
    end
  end

  assign c    = r_c;
  assign busy = r_busy;
  assign done = r_done;

endmodule
